// File: rtl/imm_ext_ctrl_if.sv
// Handshake bundle between the decode stage, the immediate-extension buffer
// and the EX stage. The master side feeds instructions and consumes results;
// the slave side is the imm_ext_ctrl block itself.
interface imm_ext_ctrl_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_mode;
    logic        out_illegal;

    modport master (
        output in_valid,
        output in_instr,
        input  in_ready,
        output flush,
        input  out_valid,
        output out_ready,
        input  out_imm,
        input  out_mode,
        input  out_illegal
    );

    modport slave (
        input  in_valid,
        input  in_instr,
        output in_ready,
        input  flush,
        output out_valid,
        input  out_ready,
        output out_imm,
        output out_mode,
        output out_illegal
    );
endinterface

// File: rtl/imm_ext_ctrl.sv
// Immediate-extension controller: decodes the immediate field of a MIPS
// instruction and holds the result in a 2-entry in-order buffer between the
// decode and EX stages. Outputs come straight from the head registers, which
// are kept at zero whenever the buffer is empty.
module imm_ext_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    imm_ext_ctrl_if.slave bus
);

    // Only a two-deep buffer is implemented; any other depth is a build error.
    if (DEPTH != 2) begin : g_depth_check
        $error("imm_ext_ctrl supports DEPTH == 2 only");
    end

    localparam logic [2:0] MODE_NONE   = 3'd0;
    localparam logic [2:0] MODE_SIGN   = 3'd1;
    localparam logic [2:0] MODE_ZERO   = 3'd2;
    localparam logic [2:0] MODE_LUI    = 3'd3;
    localparam logic [2:0] MODE_SHAMT  = 3'd4;
    localparam logic [2:0] MODE_BRANCH = 3'd5;
    localparam logic [2:0] MODE_JUMP   = 3'd6;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state;

    logic [31:0] head_imm;
    logic [2:0]  head_mode;
    logic        head_illegal;
    logic [31:0] tail_imm;
    logic [2:0]  tail_mode;
    logic        tail_illegal;

    logic [31:0] dec_imm;
    logic [2:0]  dec_mode;
    logic        dec_illegal;

    logic        accept;
    logic        pop;

    logic [5:0]  opcode;
    logic [5:0]  funct;

    assign opcode = bus.in_instr[31:26];
    assign funct  = bus.in_instr[5:0];

    // Handshake flags depend only on registered state, so there is no
    // combinational path from out_ready to in_ready or from in_valid to pop.
    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = (state != EMPTY);
    assign accept        = bus.in_valid && (state != FULL);
    assign pop           = (state != EMPTY) && bus.out_ready;

    assign bus.out_imm     = head_imm;
    assign bus.out_mode    = head_mode;
    assign bus.out_illegal = head_illegal;

    // Purely combinational decode of the incoming instruction word.
    always_comb begin
        dec_imm     = 32'd0;
        dec_mode    = MODE_NONE;
        dec_illegal = 1'b0;
        case (opcode)
            6'b000000: begin
                if (funct == 6'b000000 || funct == 6'b000010 || funct == 6'b000011) begin
                    dec_mode = MODE_SHAMT;
                    dec_imm  = {27'd0, bus.in_instr[10:6]};
                end
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b100011, 6'b101011: begin
                dec_mode = MODE_SIGN;
                dec_imm  = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
            end
            6'b001100, 6'b001101, 6'b001110: begin
                dec_mode = MODE_ZERO;
                dec_imm  = {16'd0, bus.in_instr[15:0]};
            end
            6'b001111: begin
                dec_mode = MODE_LUI;
                dec_imm  = {bus.in_instr[15:0], 16'd0};
            end
            6'b000100, 6'b000101: begin
                dec_mode = MODE_BRANCH;
                dec_imm  = {{14{bus.in_instr[15]}}, bus.in_instr[15:0], 2'b00};
            end
            6'b000010, 6'b000011: begin
                dec_mode = MODE_JUMP;
                dec_imm  = {4'd0, bus.in_instr[25:0], 2'b00};
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Buffer FSM: reset beats flush, flush beats any accept or pop, and
    // vacated slots are zeroed so empty outputs read as zero.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            state        <= EMPTY;
            head_imm     <= 32'd0;
            head_mode    <= MODE_NONE;
            head_illegal <= 1'b0;
            tail_imm     <= 32'd0;
            tail_mode    <= MODE_NONE;
            tail_illegal <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state        <= ONE;
                        head_imm     <= dec_imm;
                        head_mode    <= dec_mode;
                        head_illegal <= dec_illegal;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_imm     <= dec_imm;
                        head_mode    <= dec_mode;
                        head_illegal <= dec_illegal;
                    end else if (pop) begin
                        state        <= EMPTY;
                        head_imm     <= 32'd0;
                        head_mode    <= MODE_NONE;
                        head_illegal <= 1'b0;
                    end else if (accept) begin
                        state        <= FULL;
                        tail_imm     <= dec_imm;
                        tail_mode    <= dec_mode;
                        tail_illegal <= dec_illegal;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state        <= ONE;
                        head_imm     <= tail_imm;
                        head_mode    <= tail_mode;
                        head_illegal <= tail_illegal;
                        tail_imm     <= 32'd0;
                        tail_mode    <= MODE_NONE;
                        tail_illegal <= 1'b0;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Self-checking bench for imm_ext_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based reference model of the buffer.
module tb_imm_ext_ctrl;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  mode;
        logic        ill;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;
    bit   check_en     = 1'b0;

    entry_t model_q[$];

    imm_ext_ctrl_if bus();

    imm_ext_ctrl #(.DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Reference decode written straight from the instruction-set rules.
    function automatic entry_t ref_decode(input logic [31:0] w);
        entry_t      e;
        logic [31:0] s16;
        s16    = 32'($signed(w[15:0]));
        e.imm  = 32'd0;
        e.mode = 3'd0;
        e.ill  = 1'b0;
        case (w[31:26])
            6'd0: begin
                if (w[5:0] inside {6'd0, 6'd2, 6'd3}) begin
                    e.mode = 3'd4;
                    e.imm  = 32'(w[10:6]);
                end
            end
            6'd8, 6'd9, 6'd10, 6'd11, 6'd35, 6'd43: begin
                e.mode = 3'd1;
                e.imm  = s16;
            end
            6'd12, 6'd13, 6'd14: begin
                e.mode = 3'd2;
                e.imm  = 32'(w[15:0]);
            end
            6'd15: begin
                e.mode = 3'd3;
                e.imm  = 32'(w[15:0]) * 32'd65536;
            end
            6'd4, 6'd5: begin
                e.mode = 3'd5;
                e.imm  = s16 * 32'd4;
            end
            6'd2, 6'd3: begin
                e.mode = 3'd6;
                e.imm  = 32'(w[25:0]) * 32'd4;
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Reference buffer: occupancy and order tracked with a plain queue.
    always @(posedge clk) begin
        bit acc;
        bit pop;
        if (reset || bus.flush) begin
            model_q.delete();
        end else begin
            acc = bus.in_valid && (model_q.size() < 2);
            pop = (model_q.size() > 0) && bus.out_ready;
            if (pop) void'(model_q.pop_front());
            if (acc) model_q.push_back(ref_decode(bus.in_instr));
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        entry_t h;
        if (check_en) begin
            h = (model_q.size() > 0) ? model_q[0] : entry_t'(0);
            checkOutput("model_out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
            checkOutput("model_in_ready", 32'(bus.in_ready), 32'(model_q.size() < 2));
            checkOutput("model_out_imm", bus.out_imm, h.imm);
            checkOutput("model_out_mode", 32'(bus.out_mode), 32'(h.mode));
            checkOutput("model_out_illegal", 32'(bus.out_illegal), 32'(h.ill));
        end
    end

    // Drive one cycle of inputs, then return 1 time unit after the edge.
    task automatic applyStimulus(input bit v, input logic [31:0] instr, input bit rdy, input bit fl, input bit rst);
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.out_ready = rdy;
        bus.flush     = fl;
        reset         = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic checkHead(input string name, input bit v, input logic [31:0] imm, input logic [2:0] mode, input bit ill);
        checkOutput({name, "_valid"}, 32'(bus.out_valid), 32'(v));
        checkOutput({name, "_imm"}, bus.out_imm, imm);
        checkOutput({name, "_mode"}, 32'(bus.out_mode), 32'(mode));
        checkOutput({name, "_illegal"}, 32'(bus.out_illegal), 32'(ill));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops[16];
        logic [5:0]  fns[5];
        logic [31:0] w;
        ops = '{6'd0, 6'd8, 6'd9, 6'd10, 6'd11, 6'd35, 6'd43, 6'd12,
                6'd13, 6'd14, 6'd15, 6'd4, 6'd5, 6'd2, 6'd3, 6'd63};
        fns = '{6'd0, 6'd2, 6'd3, 6'd8, 6'd32};
        w = $urandom;
        if ($urandom_range(0, 9) == 0) return w;
        w[31:26] = ops[$urandom_range(0, 15)];
        if (w[31:26] == 6'd0) w[5:0] = fns[$urandom_range(0, 4)];
        return w;
    endfunction

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        reset         = 1'b1;
        #1;
        applyStimulus(0, 32'd0, 0, 0, 1);
        applyStimulus(0, 32'd0, 0, 0, 1);
        check_en = 1'b1;
        checkHead("reset", 0, 32'd0, 3'd0, 0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);

        // Single addi through the buffer.
        applyStimulus(1, 32'h2008FFFC, 1, 0, 0);
        checkHead("addi", 1, 32'hFFFFFFFC, 3'd1, 0);
        applyStimulus(0, 32'd0, 1, 0, 0);
        checkOutput("addi_drained", 32'(bus.out_valid), 32'd0);

        // Back-to-back stream, one result per cycle.
        applyStimulus(1, 32'h3508F000, 1, 0, 0);
        checkHead("ori", 1, 32'h0000F000, 3'd2, 0);
        applyStimulus(1, 32'h3C081234, 1, 0, 0);
        checkHead("lui", 1, 32'h12340000, 3'd3, 0);
        applyStimulus(1, 32'h00084080, 1, 0, 0);
        checkHead("sll", 1, 32'h00000002, 3'd4, 0);
        applyStimulus(1, 32'h08000010, 1, 0, 0);
        checkHead("j", 1, 32'h00000040, 3'd6, 0);
        applyStimulus(0, 32'd0, 1, 0, 0);
        checkOutput("stream_drained", 32'(bus.out_valid), 32'd0);

        // Stall with two entries held, then release.
        applyStimulus(1, 32'h1000FFFF, 0, 0, 0);
        checkHead("beq", 1, 32'hFFFFFFFC, 3'd5, 0);
        applyStimulus(1, 32'h20080005, 0, 0, 0);
        checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
        checkHead("beq_held", 1, 32'hFFFFFFFC, 3'd5, 0);
        applyStimulus(1, 32'h3C08AAAA, 0, 0, 0);
        checkHead("beq_held2", 1, 32'hFFFFFFFC, 3'd5, 0);
        applyStimulus(0, 32'd0, 1, 0, 0);
        checkHead("addi5", 1, 32'h00000005, 3'd1, 0);
        applyStimulus(0, 32'd0, 1, 0, 0);
        checkOutput("stall_drained", 32'(bus.out_valid), 32'd0);

        // Flush while full, with a simultaneous offer.
        applyStimulus(1, 32'h2008000A, 0, 0, 0);
        applyStimulus(1, 32'h2008000B, 0, 0, 0);
        applyStimulus(1, 32'h2008000C, 0, 1, 0);
        checkHead("flush", 0, 32'd0, 3'd0, 0);
        checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(0, 32'd0, 1, 0, 0);
        checkOutput("flush_after", 32'(bus.out_valid), 32'd0);

        // Unsupported opcode.
        applyStimulus(1, 32'hFC000000, 0, 0, 0);
        checkHead("illegal", 1, 32'd0, 3'd0, 1);
        applyStimulus(0, 32'd0, 1, 0, 0);

        // Unsupported R-type funct is not illegal.
        applyStimulus(1, 32'h01095020, 0, 0, 0);
        checkHead("add", 1, 32'd0, 3'd0, 0);
        applyStimulus(0, 32'd0, 1, 0, 0);

        // Reset while full and consuming.
        applyStimulus(1, 32'h2008000D, 0, 0, 0);
        applyStimulus(1, 32'h2008000E, 0, 0, 0);
        applyStimulus(0, 32'd0, 1, 0, 1);
        checkHead("reset_full", 0, 32'd0, 3'd0, 0);
        checkOutput("reset_full_in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(0, 32'd0, 1, 0, 0);
        checkOutput("reset_full_after", 32'(bus.out_valid), 32'd0);

        // Randomized traffic checked by the per-cycle model compare.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, rand_instr(),
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 99) == 0);
        end

        applyStimulus(0, 32'd0, 1, 0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/imm_ext_ctrl.md
IMM_EXT_CTRL -- requirements
Module: imm_ext_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2, fixed buffer depth (only 2 supported).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  decode stage presents an instruction.
REQ-005 SHALL have port in_instr  input  32  raw MIPS instruction word.
REQ-006 SHALL have port in_ready  output  1  block can accept an instruction this cycle.
REQ-007 SHALL have port flush  input  1  discard all buffered entries (branch mispredict or jump).
REQ-008 SHALL have port out_valid  output  1  buffer head holds a valid entry.
REQ-009 SHALL have port out_ready  input  1  EX stage consumes head this cycle; low means stall.
REQ-010 SHALL have port out_imm  output  32  extended immediate of the head entry.
REQ-011 SHALL have port out_mode  output  3  extension mode of the head entry.
REQ-012 SHALL have port out_illegal  output  1  head opcode/funct is unsupported.

Function
REQ-013 SHALL decode the mode from in_instr[31:26] and, when opcode is 000000, from funct in_instr[5:0]; mode codes: 0 NONE, 1 SIGN, 2 ZERO, 3 LUI, 4 SHAMT, 5 BRANCH, 6 JUMP.
REQ-014 SIGN SHALL apply to addi 001000, addiu 001001, slti 001010, sltiu 001011, lw 100011, sw 101011: imm = {16{instr[15]}, instr[15:0]}.
REQ-015 ZERO SHALL apply to andi 001100, ori 001101, xori 001110: imm = {16'b0, instr[15:0]}.
REQ-016 LUI SHALL apply to 001111: imm = {instr[15:0], 16'b0}.
REQ-017 SHAMT SHALL apply to R-type funct sll 000000, srl 000010, sra 000011: imm = {27'b0, instr[10:6]}; other R-type funct SHALL give NONE, imm 0, illegal 0.
REQ-018 BRANCH SHALL apply to beq 000100, bne 000101: imm = {14{instr[15]}, instr[15:0], 2'b00}.
REQ-019 JUMP SHALL apply to j 000010, jal 000011: imm = {4'b0, instr[25:0], 2'b00}.
REQ-020 Any other opcode SHALL give mode NONE, imm 0, illegal 1.
REQ-021 Decode SHALL be combinational on in_instr; the result SHALL be written into the buffer on accept (in_valid && in_ready).
REQ-022 The buffer SHALL be an in-order 2-entry FIFO with FSM states EMPTY, ONE, FULL; out_valid = (state != EMPTY); in_ready = (state != FULL); both driven from registered state only.
REQ-023 Transitions: EMPTY+accept -> ONE; ONE+accept, no pop -> FULL; ONE+pop, no accept -> EMPTY; ONE+accept+pop -> ONE holding the new entry; FULL+pop -> ONE, second entry promoted to head; all other cases hold state.
REQ-024 Latency SHALL be 1 cycle: an entry accepted at edge N is on out_* with out_valid=1 after edge N.
REQ-025 While out_valid && !out_ready, out_imm, out_mode and out_illegal SHALL remain stable.
REQ-026 Pop (out_valid && out_ready) SHALL NOT depend combinationally on in_valid; in_ready SHALL NOT depend combinationally on out_ready.
REQ-027 flush SHALL take priority over accept and pop: after the edge, state = EMPTY and any entry accepted in the same cycle SHALL be dropped.
REQ-028 When out_valid = 0, out_imm, out_mode and out_illegal SHALL be 0.

Reset
REQ-029 reset SHALL take priority over flush and all handshakes; after a reset edge: state EMPTY, in_ready 1, out_valid 0, out_imm 0, out_mode 0, out_illegal 0, storage cleared.
REQ-030 Asserting reset mid-operation, including in FULL, SHALL discard all entries with no output beat on that or the following cycle.

Verification
REQ-031 Reset, then accept addi 0x2008FFFC with out_ready=1 -> next cycle out_valid 1, out_mode 1, out_imm 0xFFFFFFFC; following cycle out_valid 0.
REQ-032 Back-to-back ori 0x3508F000, lui 0x3C081234, sll 0x00084080, j 0x08000010, out_ready=1 -> out_imm 0x0000F000, 0x12340000, 0x00000002, 0x00000040 in order, modes 2,3,4,6, one per cycle.
REQ-033 out_ready=0, accept beq 0x1000FFFF then addi 0x20080005 -> state FULL, in_ready 0, head out_imm 0xFFFFFFFC (mode 5) held stable; raise out_ready -> 0xFFFFFFFC then 0x00000005 on consecutive cycles.
REQ-034 FULL with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid 0, in_ready 1, no entry from that cycle ever appears.
REQ-035 Accept opcode 111111 (0xFC000000) -> out_illegal 1, out_mode 0, out_imm 0.
REQ-036 Reset asserted while FULL with out_ready=1 -> next cycle out_valid 0, all outputs 0, in_ready 1.
